// File: rtl/shift_pkg.sv
// Shared encodings for the shift-register sequencer.
// FSM states and pattern-mode constants.
package shift_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] MD_ROL  = 2'b00;
  localparam logic [1:0] MD_ROR  = 2'b01;
  localparam logic [1:0] MD_PING = 2'b10;
  localparam logic [1:0] MD_JOHN = 2'b11;

endpackage

// File: rtl/step_prescaler.sv
// Free-running step prescaler: counts 0..DIV-1 while enabled.
// tick marks the last count; clr beats en.
module step_prescaler #(
  parameter int N   = 26,
  parameter int DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [N-1:0] LP_LAST = N'(DIV - 1);

  logic [N-1:0] r_cnt;

  assign tick = en && (r_cnt == LP_LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Pattern sequencer: IDLE/RUN/PAUSE FSM driving a W-bit
// pattern register through rotate, ping-pong and Johnson modes.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int W   = 8,
  parameter int DIV = 50000000,
  parameter int N   = 26
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         pause,
  input  logic         stop,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [1:0]   mode,
  output logic [W-1:0] q,
  output logic         dir,
  output logic         busy,
  output logic         step
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_q;
  logic [W-1:0] w_q_nxt;
  logic         r_dir;
  logic         w_dir_nxt;
  logic [1:0]   r_mode;
  logic [1:0]   w_mode_nxt;
  logic         r_step;
  logic         w_step_nxt;
  logic [W-1:0] w_sh_q;
  logic         w_sh_dir;
  logic         w_cnt_en;
  logic         w_cnt_clr;
  logic         w_tick;

  // Counter runs only in RUN with no stop/pause this cycle.
  assign w_cnt_en  = (r_state == ST_RUN) && !stop && !pause;
  assign w_cnt_clr = stop || ((r_state == ST_IDLE) && start);

  step_prescaler #(
    .N   (N),
    .DIV (DIV)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (w_cnt_en),
    .clr   (w_cnt_clr),
    .tick  (w_tick)
  );

  always_comb begin
    w_sh_q   = r_q;
    w_sh_dir = r_dir;
    unique case (r_mode)
      MD_ROL:  w_sh_q = {r_q[W-2:0], r_q[W-1]};
      MD_ROR:  w_sh_q = {r_q[0], r_q[W-1:1]};
      MD_PING: begin
        if (!r_dir && r_q[W-1]) begin
          w_sh_dir = 1'b1;
          w_sh_q   = r_q >> 1;
        end else if (r_dir && r_q[0]) begin
          w_sh_dir = 1'b0;
          w_sh_q   = r_q << 1;
        end else begin
          w_sh_q = r_dir ? (r_q >> 1) : (r_q << 1);
        end
      end
      MD_JOHN: w_sh_q = {r_q[W-2:0], ~r_q[W-1]};
      default: w_sh_q = r_q;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_dir_nxt   = r_dir;
    w_mode_nxt  = r_mode;
    w_step_nxt  = 1'b0;
    if (stop) begin
      w_state_nxt = ST_IDLE;
      w_q_nxt     = '0;
      w_dir_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (pause) begin
            w_state_nxt = ST_PAUSE;
          end else if (w_tick) begin
            w_q_nxt    = w_sh_q;
            w_dir_nxt  = w_sh_dir;
            w_step_nxt = 1'b1;
          end
        end
        ST_IDLE, ST_PAUSE: begin
          if (start) begin
            w_state_nxt = ST_RUN;
            w_mode_nxt  = mode;
            if (r_state == ST_IDLE) begin
              w_dir_nxt = (mode == MD_ROR);
            end
          end else if (load) begin
            w_q_nxt = load_val;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_q     <= '0;
      r_dir   <= 1'b0;
      r_mode  <= MD_ROL;
      r_step  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_dir   <= w_dir_nxt;
      r_mode  <= w_mode_nxt;
      r_step  <= w_step_nxt;
    end
  end

  assign q    = r_q;
  assign dir  = r_dir;
  assign busy = (r_state == ST_RUN);
  assign step = r_step;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl (W=8, DIV=4).
// Expected steps are queued at stimulus time and popped on step pulses.
module tb_shift_seq_ctrl;

  localparam int W   = 8;
  localparam int DIV = 4;
  localparam int N   = 4;

  typedef struct {
    logic [W-1:0] q;
    logic         d;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         stop = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] q;
  logic         dir;
  logic         busy;
  logic         step;

  int   total = 0;
  int   bad = 0;
  exp_t sbq[$];

  shift_seq_ctrl #(
    .W   (W),
    .DIV (DIV),
    .N   (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .load     (load),
    .load_val (load_val),
    .mode     (mode),
    .q        (q),
    .dir      (dir),
    .busy     (busy),
    .step     (step)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int v, input logic d);
    exp_t e;
    e.q = v[W-1:0];
    e.d = d;
    return e;
  endfunction

  task automatic sb_drain(input int first_gap);
    exp_t         e;
    int           n;
    int           gap;
    logic [W-1:0] prev;
    gap  = first_gap;
    prev = q;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!step) begin
          total++;
          if (q !== prev) begin
            bad++;
            $display("FAIL hold: q=%h while step low, required %h", q, prev);
          end
        end
      end while (!step && n < 2 * DIV);
      total++;
      if (step !== 1'b1 || n != gap) begin
        bad++;
        $display("FAIL step_time: step=%b after %0d cycles, required 1 after %0d",
                 step, n, gap);
      end
      total++;
      if (q !== e.q) begin
        bad++;
        $display("FAIL q: got %h, required %h", q, e.q);
      end
      total++;
      if (dir !== e.d) begin
        bad++;
        $display("FAIL dir: got %b, required %b (q=%h)", dir, e.d, e.q);
      end
      prev = q;
      gap  = DIV;
    end
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (q !== '0 || dir !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stop: q=%h dir=%b busy=%b, required 00 0 0", q, dir, busy);
    end
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load = 1'b0;
    total++;
    if (q !== v) begin
      bad++;
      $display("FAIL load: q=%h, required %h", q, v);
    end
  endtask

  task automatic do_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL start_busy: busy=%b, required 1", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (q !== '0 || dir !== 1'b0 || busy !== 1'b0 || step !== 1'b0) begin
      bad++;
      $display("FAIL reset: q=%h dir=%b busy=%b step=%b, required all 0",
               q, dir, busy, step);
    end
  endtask

  task automatic test_rol();
    do_stop();
    do_load(8'h01);
    do_start(2'b00);
    for (int i = 1; i <= 4; i++) sbq.push_back(mk(1 << (i % W), 1'b0));
    sb_drain(DIV);
    start    = 1'b1;
    load     = 1'b1;
    load_val = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    load  = 1'b0;
    for (int i = 5; i <= 8; i++) sbq.push_back(mk(1 << (i % W), 1'b0));
    sb_drain(DIV - 1);
  endtask

  task automatic test_ror();
    do_stop();
    do_load(8'h81);
    do_start(2'b01);
    sbq.push_back(mk('hC0, 1'b1));
    sbq.push_back(mk('h60, 1'b1));
    sbq.push_back(mk('h30, 1'b1));
    sb_drain(DIV);
  endtask

  task automatic test_ping();
    int t;
    int p;
    do_stop();
    do_load(8'h01);
    do_start(2'b10);
    for (int i = 1; i <= 16; i++) begin
      t = i % 14;
      p = (t <= 7) ? t : 14 - t;
      sbq.push_back(mk(1 << p, (t >= 8) || (t == 0)));
    end
    sb_drain(DIV);
  endtask

  task automatic test_john();
    int v;
    do_stop();
    do_start(2'b11);
    for (int i = 1; i <= 16; i++) begin
      if (i <= W) v = (1 << i) - 1;
      else v = (32'hFF << (i - W)) & 32'hFF;
      sbq.push_back(mk(v, 1'b0));
    end
    sb_drain(DIV);
  endtask

  task automatic test_pause();
    do_stop();
    do_load(8'h01);
    do_start(2'b00);
    sbq.push_back(mk('h02, 1'b0));
    sb_drain(DIV);
    @(negedge clk);
    @(negedge clk);
    pause = 1'b1;
    @(negedge clk);
    pause = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL pause_busy: busy=%b, required 0", busy);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (q !== 8'h02 || step !== 1'b0) begin
        bad++;
        $display("FAIL pause_hold: q=%h step=%b, required 02 0", q, step);
      end
    end
    do_start(2'b00);
    sbq.push_back(mk('h04, 1'b0));
    sbq.push_back(mk('h08, 1'b0));
    sb_drain(DIV - 2);
  endtask

  task automatic test_back_to_back();
    do_stop();
    do_load(8'h01);
    mode     = 2'b00;
    start    = 1'b1;
    load     = 1'b1;
    load_val = 8'hAA;
    @(negedge clk);
    start = 1'b0;
    load  = 1'b0;
    total++;
    if (busy !== 1'b1 || q !== 8'h01) begin
      bad++;
      $display("FAIL start_load: busy=%b q=%h, required 1 01", busy, q);
    end
    repeat (DIV - 1) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (q !== '0 || step !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL stop_tick: q=%h step=%b busy=%b, required 00 0 0",
               q, step, busy);
    end
    @(negedge clk);
    total++;
    if (step !== 1'b0 || q !== '0) begin
      bad++;
      $display("FAIL stop_after: step=%b q=%h, required 0 00", step, q);
    end
  endtask

  task automatic test_reset_run();
    do_stop();
    do_load(8'h81);
    do_start(2'b01);
    repeat (DIV - 1) @(negedge clk);
    total++;
    if (dir !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset: dir=%b busy=%b, required 1 1", dir, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (q !== '0 || dir !== 1'b0 || busy !== 1'b0 || step !== 1'b0) begin
      bad++;
      $display("FAIL reset_run: q=%h dir=%b busy=%b step=%b, required all 0",
               q, dir, busy, step);
    end
  endtask

  initial begin
    test_reset();
    test_rol();
    test_ror();
    test_ping();
    test_john();
    test_pause();
    test_back_to_back();
    test_reset_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Sequencer for the shift-register lab design. It owns a free-running step prescaler and drives a W-bit pattern register through rotate, ping-pong and Johnson patterns at a rate of one step per DIV clocks. It accepts start, pause, stop and load commands from board buttons, already debounced upstream, and feeds q to the LED bank.

## Interface
- W, 8, pattern width (W ≥ 2)
- DIV, 50000000, clocks per step (1 s at 50 MHz); DIV ≥ 2
- N, 26, prescaler counter width; must satisfy 2^N > DIV
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  level, sampled each clk
- pause  in  1  level, sampled each clk
- stop  in  1  level, sampled each clk
- load  in  1  load load_val into q (IDLE/PAUSE only)
- load_val  in  W  pattern to load
- mode  in  2  00 rotate left, 01 rotate right, 10 ping-pong, 11 Johnson
- q  out  W  pattern register
- dir  out  1  current direction; 0 = left, 1 = right
- busy  out  1  state == RUN
- step  out  1  one-cycle pulse, high in the first cycle q shows a new stepped value

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, RUN, PAUSE.
- Command priority within a cycle: stop > pause > start > load.
  - stop from any state goes to IDLE; q, dir and the prescaler clear to 0.
  - pause in RUN goes to PAUSE; q and dir are held, and the prescaler count is held.
  - start in IDLE or PAUSE goes to RUN and latches mode into mode_r.
    - From IDLE, the prescaler clears and dir is set to (mode == 01).
    - From PAUSE, the prescaler resumes from its held count and dir is kept.
  - start in RUN and pause in IDLE/PAUSE are ignored.
  - load in IDLE or PAUSE sets q <= load_val. load is ignored in RUN.
  - start and load in the same cycle: start wins and the load is dropped.
- Prescaler counts 0..DIV-1 while in RUN only. tick = (cnt == DIV-1), then cnt wraps to 0.
- On each tick, q updates according to mode_r:
  - 00: q <= {q[W-2:0], q[W-1]}
  - 01: q <= {q[0], q[W-1:1]}
  - 10: if dir==0 and q[W-1]==1, set dir <= 1 and shift right logically. If dir==1 and q[0]==1, set dir <= 0 and shift left logically. Otherwise shift logically in direction dir, filling with 0.
  - 11: q <= {q[W-2:0], ~q[W-1]} (period 2W steps).
- mode changes in RUN have no effect until the next start.
- q == 0 in rotate or ping-pong stays 0. This is legal, not an error.

## Timing
- Reset values: state IDLE, q = 0, dir = 0, busy = 0, step = 0, cnt = 0, mode_r = 00.
- start sampled high at edge k gives busy = 1 from edge k onward. The first q update occurs at edge k+DIV; after that, q updates every DIV edges while in RUN.
- step is registered. It is high exactly in the cycle after the edge that updated q, and never two consecutive cycles (DIV ≥ 2).
- pause at edge p: no q update at edge p, even if tick would fire there. Resuming at edge r gives the next update at edge r + (DIV − cnt_held).
- stop or reset coinciding with a tick: clear wins, and step stays 0.
- load is visible on q one cycle after the edge at which it is sampled.

## Structure
- A shared package, shift_pkg, holds:
  - state encodings ST_IDLE = 0, ST_RUN = 1, ST_PAUSE = 2
  - mode constants MD_ROL, MD_ROR, MD_PING, MD_JOHN
- One sub-module, step_prescaler (parameters N, DIV):
  - ports clk, reset, en, clr, tick
  - keeps the counter when en = 0
  - clr has priority over en
- The top holds the FSM, mode_r, the pattern register and the step flop.

## Test plan
Bench uses W=8, DIV=4.
- Reset, then load 8'h01, then start with mode 00 → busy = 1; q = 02, 04, 08 … 80, 01 at 4-cycle spacing; step pulses align with each change.
- load 8'h81, start with mode 01 → q = C0, 60, 30; dir = 1 throughout.
- load 8'h01, start with mode 10, run 16 steps → q walks to 80, dir flips to 1 on the next step (q = 40), returns to 01, then dir flips to 0.
- Idle with q = 0, start with mode 11 → q = 01, 03, 07 … FF, FE, FC … 00; period 16 steps.
- Pause 2 cycles after a step, hold 10 cycles, restart → next update 2 cycles after restart.
- Start+load in the same cycle, and stop coinciding with a tick → load dropped and busy = 1 for the first; q = 00, step = 0, state IDLE for the second. Reset asserted mid-RUN → all outputs at reset values next cycle.
